// File: rtl/ads8556_frame_packer.sv
// -----------------------------------------------------------------------------
// ads8556_frame_packer
//
// Captures each six-channel ADS8556 sample set into a frame FIFO and serialises
// the stored frames onto a 32-bit AXI4-Stream master. Frames that arrive while
// the FIFO is full are dropped and counted.
//
// Each FIFO entry is {seq, ch5, ch4, ch3, ch2, ch1, ch0} (112 bits). The 16-bit
// seq advances on every enabled strobe, stored or dropped, so gaps in seq show
// where frames were lost.
//
// Compile-time option:
//   CH_HDR_EN  defined   : 4-word frames {SYNC_WORD,seq},{ch1,ch0},{ch3,ch2},{ch5,ch4}
//              undefined : 3-word frames {ch1,ch0},{ch3,ch2},{ch5,ch4}
//
// Parameters:
//   FIFO_AW    log2 of FIFO depth in frames (1..8)
//   SYNC_WORD  header marker, only transmitted with CH_HDR_EN
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_ch0..data_ch5    converted samples, valid when data_valid=1
//   data_valid            one-cycle strobe for a complete sample set
//   enable                level-sensitive capture enable
//   m_axis_tdata/tvalid/tready/tlast   AXI4-Stream master
//   ovf_cnt               saturating count of dropped frames
//   fifo_level            frames stored, excluding the frame in flight
// -----------------------------------------------------------------------------
module ads8556_frame_packer #(
   parameter int          FIFO_AW   = 4,
   parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        data_ch0,
   input  logic [15:0]        data_ch1,
   input  logic [15:0]        data_ch2,
   input  logic [15:0]        data_ch3,
   input  logic [15:0]        data_ch4,
   input  logic [15:0]        data_ch5,
   input  logic               data_valid,
   input  logic               enable,
   output logic [31:0]        m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast,
   output logic [15:0]        ovf_cnt,
   output logic [FIFO_AW:0]   fifo_level
);

`ifdef CH_HDR_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif
   localparam int               DEPTH   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_ONE = 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE = 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   logic [111:0]        mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr;
   logic [FIFO_AW-1:0]  rd_ptr;
   logic [15:0]         seq;
   logic [111:0]        head;
   logic [95:0]         frame;      // channel payload of the frame in flight
   logic [1:0]          widx;
   logic [31:0]         head_w0;
   logic [31:0]         next_w;     // word widx+1 of the frame in flight

   logic strobe, fifo_full, fifo_empty, push, pop, hs, last_hs;

   // Full is decided on the level before any same-edge pop, so a strobe that
   // meets a full FIFO is dropped even if the output stage pops on that edge.
   assign fifo_full  = fifo_level[FIFO_AW];
   assign fifo_empty = (fifo_level == '0);
   assign strobe     = data_valid & enable;
   assign push       = strobe & ~fifo_full;
   assign hs         = m_axis_tvalid & m_axis_tready;
   assign last_hs    = hs & (widx == LAST_IDX);
   // Pop when idle, or on the final handshake so the next frame follows with
   // no bubble.
   assign pop        = ~fifo_empty & ((state == IDLE) | last_hs);
   assign head       = mem[rd_ptr];

`ifdef CH_HDR_EN
   assign head_w0 = {SYNC_WORD, head[111:96]};

   always_comb begin
      next_w = frame[95:64];
      case (widx)
         2'd0:    next_w = frame[31:0];
         2'd1:    next_w = frame[63:32];
         default: next_w = frame[95:64];
      endcase
   end
`else
   // Word 0 is launched straight from the FIFO head; seq and the sync marker
   // are not transmitted in this build.
   logic unused_bits;
   assign unused_bits = ^{frame[31:0], head[111:96], SYNC_WORD};
   assign head_w0     = head[31:0];

   always_comb begin
      next_w = frame[95:64];
      case (widx)
         2'd0:    next_w = frame[63:32];
         default: next_w = frame[95:64];
      endcase
   end
`endif

   // NOTE: the storage array has no reset; resetting the pointers and level
   // is enough to discard its contents, and it lets the array map to RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {seq, data_ch5, data_ch4, data_ch3, data_ch2, data_ch1, data_ch0};
   end

   // NOTE: all state registers use non-blocking assignments so every block
   // sees pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         seq        <= '0;
         ovf_cnt    <= '0;
      end else begin
         if (strobe) begin
            seq <= seq + 16'd1;
            if (fifo_full && (ovf_cnt != 16'hFFFF))
               ovf_cnt <= ovf_cnt + 16'd1;
         end
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_ONE;
            2'b01:   fifo_level <= fifo_level - LVL_ONE;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Output FSM: all stream outputs are registered, so tvalid never depends
   // combinationally on tready and the word holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         widx          <= '0;
         frame         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state         <= SEND;
                  frame         <= head[95:0];
                  widx          <= '0;
                  m_axis_tdata  <= head_w0;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b0;
               end
            end
            SEND: begin
               if (last_hs) begin
                  if (pop) begin
                     frame        <= head[95:0];
                     widx         <= '0;
                     m_axis_tdata <= head_w0;
                     m_axis_tlast <= 1'b0;
                  end else begin
                     state         <= IDLE;
                     widx          <= '0;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                  end
               end else if (hs) begin
                  widx         <= widx + 2'd1;
                  m_axis_tdata <= next_w;
                  m_axis_tlast <= ((widx + 2'd1) == LAST_IDX);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ads8556_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_ads8556_frame_packer
//
// Scoreboard bench for ads8556_frame_packer (FIFO_AW=2, depth 4). Stimulus
// pushes the expected stream words of every accepted frame into a queue; an
// independent monitor pops and compares on each handshake, and checks that a
// stalled beat holds steady. Works with and without CH_HDR_EN.
// -----------------------------------------------------------------------------
module tb_ads8556_frame_packer;

   localparam int AW  = 2;
   localparam int CAP = 1 << AW;
`ifdef CH_HDR_EN
   localparam int NW  = 4;
   localparam bit HDR = 1'b1;
`else
   localparam int NW  = 3;
   localparam bit HDR = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   ch [6];
   logic          data_valid;
   logic          enable;
   logic [31:0]   tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;
   logic [15:0]   ovf_cnt;
   logic [AW:0]   fifo_level;

   ads8556_frame_packer #(.FIFO_AW(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_ch0      (ch[0]),
      .data_ch1      (ch[1]),
      .data_ch2      (ch[2]),
      .data_ch3      (ch[3]),
      .data_ch4      (ch[4]),
      .data_ch5      (ch[5]),
      .data_valid    (data_valid),
      .enable        (enable),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast),
      .ovf_cnt       (ovf_cnt),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;

   // reference model state
   beat_t       exp_q[$];
   logic [15:0] m_seq;
   int          m_ovf;
   int          frames_acc;
   int          frames_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A frame is accepted while fewer than CAP stored frames plus one in
   // flight are outstanding; otherwise it is dropped and counted.
   task automatic model_capture();
      if (frames_acc - frames_done <= CAP) begin
         if (HDR) exp_q.push_back({16'hA5C3, m_seq, 1'b0});
         exp_q.push_back({ch[1], ch[0], 1'b0});
         exp_q.push_back({ch[3], ch[2], 1'b0});
         exp_q.push_back({ch[5], ch[4], 1'b1});
         frames_acc++;
      end else if (m_ovf < 65535) begin
         m_ovf++;
      end
      m_seq = m_seq + 16'd1;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_seq       = '0;
      m_ovf       = 0;
      frames_acc  = 0;
      frames_done = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a strobe for the current cycle (sampled at the next edge).
   task automatic drive_strobe();
      for (int i = 0; i < 6; i++) ch[i] = 16'($urandom);
      data_valid = 1'b1;
      if (enable) model_capture();
   endtask

   task automatic strobe();
      drive_strobe();
      tick();
      data_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      tready = 1'b1;
      for (int i = 0; i < 200 && (exp_q.size() != 0 || tvalid); i++) tick();
      check(name, exp_q.size(), 0);
   endtask

   // ---------------- monitor ----------------
   logic        stall_pend = 1'b0;
   logic [31:0] held_data;
   logic        held_last;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_pend = 1'b0;
         end else begin
            if (stall_pend) begin
               check("hold_tvalid", tvalid, 1);
               check("hold_tdata", tdata, held_data);
               check("hold_tlast", tlast, held_last);
            end
            if (tvalid && tready) begin
               check("beat_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  beat_t b;
                  b = exp_q.pop_front();
                  check("tdata", tdata, b.data);
                  check("tlast", tlast, b.last);
               end
               if (tlast) frames_done++;
            end
            stall_pend = tvalid && !tready;
            held_data  = tdata;
            held_last  = tlast;
         end
      end
   end

   // ---------------- stimulus ----------------
   int run, max_run, peak;

   initial begin
      rst_n      = 1'b0;
      data_valid = 1'b0;
      enable     = 1'b0;
      tready     = 1'b0;
      for (int i = 0; i < 6; i++) ch[i] = '0;
      model_reset();
      repeat (3) tick();

      // reset values
      check("rst_tvalid", tvalid, 0);
      check("rst_tlast", tlast, 0);
      check("rst_tdata", tdata, 0);
      check("rst_ovf", ovf_cnt, 0);
      check("rst_level", fifo_level, 0);
      rst_n = 1'b1;
      tick();

      // single frame with fixed channel values and latency check
      tready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) ch[i] = 16'(i + 1);
      data_valid = 1'b1;
      model_capture();
      tick();
      data_valid = 1'b0;
      check("lat_not_yet", tvalid, 0);
      tick();
      check("lat_w0_valid", tvalid, 1);
      drain("single_drain");

      // back-pressure: tready pattern 1,0,0,1 repeating
      tready = 1'b1;
      strobe();
      for (int i = 0; i < 24; i++) begin
         tready = (i % 4 == 0) || (i % 4 == 3);
         tick();
      end
      drain("bp_drain");

      // back-to-back frames: spacing of NW cycles keeps the pipe full
      tready  = 1'b1;
      run     = 0;
      max_run = 0;
      peak    = 0;
      for (int c = 0; c < 3 * NW + 10; c++) begin
         if (c % NW == 0 && c < 3 * NW) drive_strobe();
         else data_valid = 1'b0;
         tick();
         if (tvalid) run++; else run = 0;
         if (run > max_run) max_run = run;
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      data_valid = 1'b0;
      check("b2b_run", max_run, 3 * NW);
      check("b2b_peak", peak, 1);
      drain("b2b_drain");

      // enable gating: disabled strobes are ignored
      enable = 1'b0;
      repeat (3) strobe();
      tick();
      check("gate_level", fifo_level, 0);
      check("gate_tvalid", tvalid, 0);
      enable = 1'b1;
      strobe();
      tick();
      enable = 1'b0;          // drop mid-frame: frame still completes
      strobe();
      drain("gate_drain");

      // randomized traffic without overflow
      enable = 1'b1;
      for (int c = 0; c < 600; c++) begin
         tready = ($urandom_range(0, 2) != 0);
         enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 2) == 0 && (frames_acc - frames_done) < CAP) drive_strobe();
         else data_valid = 1'b0;
         tick();
      end
      data_valid = 1'b0;
      enable     = 1'b1;
      drain("rand_drain");
      check("rand_ovf", ovf_cnt, m_ovf);

      // overflow: tready held low, 7 strobes into a depth-4 FIFO
      rst_n = 1'b0;
      model_reset();
      tick();
      rst_n  = 1'b1;
      tready = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) strobe();
      tick();
      check("ovf_level", fifo_level, CAP);
      check("ovf_cnt", ovf_cnt, m_ovf);
      check("ovf_tvalid", tvalid, 1);
      drain("ovf_drain");
      check("ovf_level_empty", fifo_level, 0);

      // reset during W2
      tready = 1'b1;
      strobe();
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", tvalid, 0);
      check("mid_rst_tlast", tlast, 0);
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      check("post_rst_level", fifo_level, 0);
      check("post_rst_ovf", ovf_cnt, 0);
      tick();
      strobe();
      drain("post_rst_drain");

      check("final_ovf", ovf_cnt, m_ovf);
      check("final_level", fifo_level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
